// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan
//  Purpose  : Time-multiplexed driver for a four-digit seven-segment display.
//             Each digit owns a slot of DIV clock cycles: the first BLANK
//             cycles keep every anode off (anti-ghosting), and the remaining
//             cycles light the digit.  New patterns are captured into staging
//             registers on 'load' and move to the display registers only at
//             a frame boundary, so a frame never mixes old and new data.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     en           in   scan enable; 0 parks the scanner in IDLE
//     load         in   capture the four input patterns into staging
//     opcode7seg   in   active-high pattern for digit 0
//     opa7seg      in   active-high pattern for digit 1
//     opb7seg      in   active-high pattern for digit 2
//     aluRes7seg   in   active-high pattern for digit 3
//     blank_mask   in   bit i = 1 keeps digit i dark during its slot
//     seg          out  shared segment bus (polarity per SEG_ACTIVE_LOW)
//     an           out  digit enables (polarity per AN_ACTIVE_LOW)
//     digit_idx    out  digit slot currently scanned
//     frame_done   out  one-cycle pulse after the wrap out of digit 3
//     pending      out  staged data not yet moved to the display
// ============================================================================
module seg_scan #(
   parameter int RESULT_WIDTH   = 7,
   parameter int DIV            = 50000,  // cycles per slot, >= BLANK + 2
   parameter int BLANK          = 16,     // dark cycles per slot, >= 1
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    load,
   input  logic [RESULT_WIDTH-1:0] opcode7seg,
   input  logic [RESULT_WIDTH-1:0] opa7seg,
   input  logic [RESULT_WIDTH-1:0] opb7seg,
   input  logic [RESULT_WIDTH-1:0] aluRes7seg,
   input  logic [3:0]              blank_mask,
   output logic [RESULT_WIDTH-1:0] seg,
   output logic [3:0]              an,
   output logic [1:0]              digit_idx,
   output logic                    frame_done,
   output logic                    pending
);

   // -------------------------------------------------------------------------
   // Constants
   // -------------------------------------------------------------------------
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [CW-1:0] C_CNT_LAST   = CW'(DIV - 1);
   localparam logic [CW-1:0] C_BLANK_LAST = CW'(BLANK - 1);

   // Off levels double as XOR masks: XOR with the off level converts an
   // active-high pattern / one-hot into the configured output polarity.
   localparam logic [RESULT_WIDTH-1:0] C_SEG_OFF = {RESULT_WIDTH{SEG_ACTIVE_LOW}};
   localparam logic [3:0]              C_AN_OFF  = {4{AN_ACTIVE_LOW}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_BLANK = 2'd1;
   localparam logic [1:0] S_SHOW  = 2'd2;

   // -------------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------------
   logic [1:0]              r_state;
   logic [CW-1:0]           r_cnt;
   logic [RESULT_WIDTH-1:0] r_stage [4];
   logic [RESULT_WIDTH-1:0] r_disp  [4];

   logic [1:0]              w_nxt_state;
   logic [CW-1:0]           w_nxt_cnt;
   logic [1:0]              w_nxt_idx;
   logic                    w_boundary;   // entering BLANK with digit 0
   logic                    w_wrap;       // SHOW -> BLANK out of digit 3

   logic [RESULT_WIDTH-1:0] w_in [4];
   logic [RESULT_WIDTH-1:0] w_pat;
   logic [3:0]              w_onehot;
   logic                    w_lit;
   logic [RESULT_WIDTH-1:0] w_seg_nxt;
   logic [3:0]              w_an_nxt;

   assign w_in[0] = opcode7seg;
   assign w_in[1] = opa7seg;
   assign w_in[2] = opb7seg;
   assign w_in[3] = aluRes7seg;

   // -------------------------------------------------------------------------
   // Next-state logic.  The slot counter runs 0..DIV-1 straight through the
   // BLANK and SHOW phases of one slot; it is only cleared at slot start.
   // -------------------------------------------------------------------------
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_cnt   = r_cnt;
      w_nxt_idx   = digit_idx;
      w_boundary  = 1'b0;
      w_wrap      = 1'b0;

      if (!en) begin
         w_nxt_state = S_IDLE;
         w_nxt_cnt   = '0;
         w_nxt_idx   = 2'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_nxt_state = S_BLANK;
               w_nxt_cnt   = '0;
               w_nxt_idx   = 2'd0;
               w_boundary  = 1'b1;
            end
            S_BLANK: begin
               w_nxt_cnt = r_cnt + 1'b1;
               if (r_cnt == C_BLANK_LAST) begin
                  w_nxt_state = S_SHOW;
               end
            end
            S_SHOW: begin
               if (r_cnt == C_CNT_LAST) begin
                  w_nxt_state = S_BLANK;
                  w_nxt_cnt   = '0;
                  w_nxt_idx   = digit_idx + 2'd1;
                  if (digit_idx == 2'd3) begin
                     w_boundary = 1'b1;
                     w_wrap     = 1'b1;
                  end
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end
            default: begin
               w_nxt_state = S_IDLE;
               w_nxt_cnt   = '0;
               w_nxt_idx   = 2'd0;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output decode from the *next* state so the registered seg/an line up
   // with the state register.  The display registers are safe to read here:
   // they only change on entry into BLANK, when the outputs are dark anyway.
   // -------------------------------------------------------------------------
   always_comb begin
      w_pat     = r_disp[w_nxt_idx];
      w_onehot  = 4'b0001 << w_nxt_idx;
      w_lit     = (w_nxt_state == S_SHOW) && !blank_mask[w_nxt_idx];
      w_seg_nxt = w_lit ? (w_pat ^ C_SEG_OFF) : C_SEG_OFF;
      w_an_nxt  = w_lit ? (w_onehot ^ C_AN_OFF) : C_AN_OFF;
   end

   // -------------------------------------------------------------------------
   // Scan state and registered outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         digit_idx  <= 2'd0;
         frame_done <= 1'b0;
         seg        <= C_SEG_OFF;
         an         <= C_AN_OFF;
      end else begin
         r_state    <= w_nxt_state;
         r_cnt      <= w_nxt_cnt;
         digit_idx  <= w_nxt_idx;
         frame_done <= w_wrap;
         seg        <= w_seg_nxt;
         an         <= w_an_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Double-buffered pattern storage.  On a load coinciding with a frame
   // boundary the display takes the staging contents from before the edge
   // while staging takes the new inputs, so pending must remain set.  When
   // pending is clear, staging already equals the display.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_stage[i] <= '0;
            r_disp[i]  <= '0;
         end
      end else begin
         if (w_boundary && pending) begin
            for (int i = 0; i < 4; i++) begin
               r_disp[i] <= r_stage[i];
            end
         end

         if (load) begin
            for (int i = 0; i < 4; i++) begin
               r_stage[i] <= w_in[i];
            end
         end

         if (load) begin
            pending <= 1'b1;
         end else if (w_boundary) begin
            pending <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter RESULT_WIDTH, default 7: width of each segment pattern.
REQ-002 Parameter DIV, default 50000: clock cycles per digit slot; SHALL satisfy DIV >= BLANK+2.
REQ-003 Parameter BLANK, default 16: anti-ghosting cycles at the start of each slot, all anodes off; SHALL be >= 1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 1: 1 = segment output bit 0 lights a segment.
REQ-005 Parameter AN_ACTIVE_LOW, default 1: 1 = anode output bit 0 enables a digit.
REQ-006 clk  in  1  single clock; all state changes on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  scan enable.
REQ-009 load  in  1  capture request for the four input patterns.
REQ-010 opcode7seg, opa7seg, opb7seg, aluRes7seg  in  RESULT_WIDTH each  active-high patterns (bit=1 lit) for digits 0,1,2,3 respectively.
REQ-011 blank_mask  in  4  bit i=1 suppresses digit i.
REQ-012 seg  out  RESULT_WIDTH  shared segment bus, polarity per SEG_ACTIVE_LOW.
REQ-013 an  out  4  digit enables, bit i = digit i, polarity per AN_ACTIVE_LOW.
REQ-014 digit_idx  out  2  digit slot currently scanned.
REQ-015 frame_done  out  1  one-cycle pulse at frame end.
REQ-016 pending  out  1  captured data awaiting transfer to display.

Function
REQ-017 All outputs SHALL be registered; seg and an SHALL update on the same edge.
REQ-018 FSM states: IDLE, BLANK, SHOW; one slot counter cnt 0..DIV-1.
REQ-019 IDLE: an all off, seg all off, cnt=0, digit_idx=0; en=1 -> BLANK with digit_idx=0, cnt=0.
REQ-020 BLANK: an all off, seg all off; cnt increments; at cnt=BLANK-1 -> SHOW next edge.
REQ-021 SHOW: an bit digit_idx on, seg = display pattern of digit_idx; cnt increments; at cnt=DIV-1 -> BLANK, cnt=0, digit_idx = (digit_idx+1) mod 4 (3 wraps to 0).
REQ-022 frame_done SHALL be 1 for exactly the cycle following the SHOW->BLANK transition out of digit_idx=3; 0 otherwise.
REQ-023 blank_mask[i]=1: during digit i SHOW, an all off and seg all off; slot timing unchanged; mask sampled each cycle.
REQ-024 en=0 in any state -> IDLE next edge; no frame_done pulse emitted.
REQ-025 load=1 at an edge: four inputs captured into staging registers, pending=1.
REQ-026 Frame boundary = any entry into BLANK with digit_idx=0 (from IDLE or wrap from digit 3).
REQ-027 At a frame boundary with pending=1: staging copied to display registers, pending cleared.
REQ-028 load coincident with frame boundary: display receives staging value held before the edge; staging takes new inputs; pending stays 1.
REQ-029 Display registers SHALL NOT change outside frame boundaries (tear-free frames).
REQ-030 load while en=0 SHALL capture normally; transfer occurs at the IDLE->BLANK entry.

Reset
REQ-031 rst_n=0 SHALL immediately, without clock, force: state IDLE, cnt=0, digit_idx=0, frame_done=0, pending=0, staging and display registers 0, an all off, seg all off.
REQ-032 All-off levels: an=4'hF and seg=all ones when active-low; zeros when active-high.
REQ-033 Reset release SHALL be synchronous to clk; first state change no earlier than the first rising edge after rst_n=1.

Verification (DIV=8, BLANK=2, active-low outputs)
REQ-034 Reset: rst_n=0 mid-SHOW, no clock -> an=4'hF, seg=7'h7F, pending=0, frame_done=0 immediately.
REQ-035 Scan: load with opcode=7'h3F, opa=7'h06, opb=7'h5B, aluRes=7'h4F, then en=1 -> per slot 2 cycles an=4'hF, 6 cycles an=4'b1110/1101/1011/0111 with seg=~pattern (7'h40,7'h79,7'h24,7'h30); frame_done single pulse every 32 cycles.
REQ-036 Tear-free: load opa=7'h66 during digit 2 slot -> pending=1; digit 1 still shows old value until next frame; at frame boundary pending=0, next digit 1 slot seg=7'h19.
REQ-037 Mask: blank_mask=4'b0100 -> digit 2 slot an=4'hF, seg=7'h7F; other slots and frame_done period unchanged.
REQ-038 Enable drop: en=0 during digit 1 SHOW -> IDLE next edge, outputs off, no frame_done; en=1 -> restart at digit 0 BLANK.
REQ-039 Coincidence: load at wrap edge from digit 3 -> display gets prior staging, pending remains 1, new data shown one frame later.
